// File: rtl/led_mode_ctrl_if.sv
// Signal bundle between the LED mode controller and its surroundings:
// key/auto controls and breath engine input in, LED drive and mode status out.
interface led_mode_ctrl_if;
    logic       key_next;
    logic       auto_en;
    logic [3:0] breath_led;
    logic       breath_en;
    logic [3:0] led;
    logic [1:0] mode;

    modport master (
        output key_next,
        output auto_en,
        output breath_led,
        input  breath_en,
        input  led,
        input  mode
    );

    modport slave (
        input  key_next,
        input  auto_en,
        input  breath_led,
        output breath_en,
        output led,
        output mode
    );
endinterface

// File: rtl/led_mode_ctrl.sv
// Mode controller for the 4-LED bank: off, breathing pass-through, blink and
// running light, stepped by key pulse or an automatic dwell timer.
module led_mode_ctrl #(
    parameter int TICK_CYCLES = 50_000,
    parameter int BLINK_MS    = 500,
    parameter int STEP_MS     = 250,
    parameter int AUTO_MS     = 4000
) (
    input  logic           sys_clk,
    input  logic           rst_n,
    led_mode_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BREATH = 2'd1,
        BLINK  = 2'd2,
        RUN    = 2'd3
    } mode_t;

    localparam logic [15:0] TICK_LAST  = 16'(TICK_CYCLES - 1);
    localparam logic [15:0] BLINK_LAST = 16'(BLINK_MS - 1);
    localparam logic [15:0] STEP_LAST  = 16'(STEP_MS - 1);
    localparam logic [15:0] AUTO_LAST  = 16'(AUTO_MS - 1);

    mode_t       state;
    mode_t       state_next;
    logic [15:0] tick_cnt;
    logic [15:0] pat_cnt;
    logic [15:0] dwell_cnt;
    logic        tick;
    logic        phase;
    logic [3:0]  run_pat;
    logic [3:0]  led_q;
    logic        breath_en_q;
    logic        auto_active;
    logic        auto_adv;
    logic        mode_change;

    assign tick        = (tick_cnt == TICK_LAST);
    assign auto_active = bus.auto_en && (state != IDLE);
    assign auto_adv    = auto_active && tick && (dwell_cnt == AUTO_LAST);
    assign mode_change = (state_next != state);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A key press always wins over a coincident auto advance, so the two never stack.
    always_comb begin
        state_next = state;
        if (bus.key_next) begin
            case (state)
                IDLE:    state_next = BREATH;
                BREATH:  state_next = BLINK;
                BLINK:   state_next = RUN;
                default: state_next = IDLE;
            endcase
        end else if (auto_adv) begin
            case (state)
                BREATH:  state_next = BLINK;
                BLINK:   state_next = RUN;
                RUN:     state_next = BREATH;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (mode_change || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_cnt <= '0;
        end else if (mode_change || !auto_active) begin
            dwell_cnt <= '0;
        end else if (tick) begin
            dwell_cnt <= dwell_cnt + 16'd1;
        end
    end

    // One pattern counter serves both blink half-periods and running-light steps.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_cnt <= '0;
            phase   <= 1'b1;
            run_pat <= 4'b0001;
        end else if (mode_change) begin
            pat_cnt <= '0;
            phase   <= 1'b1;
            run_pat <= 4'b0001;
        end else if (tick) begin
            case (state)
                BLINK: begin
                    if (pat_cnt == BLINK_LAST) begin
                        pat_cnt <= '0;
                        phase   <= ~phase;
                    end else begin
                        pat_cnt <= pat_cnt + 16'd1;
                    end
                end
                RUN: begin
                    if (pat_cnt == STEP_LAST) begin
                        pat_cnt <= '0;
                        run_pat <= {run_pat[2:0], run_pat[3]};
                    end else begin
                        pat_cnt <= pat_cnt + 16'd1;
                    end
                end
                default: pat_cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q       <= 4'b0000;
            breath_en_q <= 1'b0;
        end else begin
            breath_en_q <= (state == BREATH);
            case (state)
                BREATH:  led_q <= bus.breath_led;
                BLINK:   led_q <= {4{phase}};
                RUN:     led_q <= run_pat;
                default: led_q <= 4'b0000;
            endcase
        end
    end

    assign bus.led       = led_q;
    assign bus.breath_en = breath_en_q;
    assign bus.mode      = state;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Self-checking bench for led_mode_ctrl with small timing parameters and a
// behavioural model that derives patterns from elapsed cycles since a mode change.
module tb_led_mode_ctrl;

    localparam int TC = 4;
    localparam int BM = 3;
    localparam int SM = 2;
    localparam int AM = 5;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b1;

    always #5 sys_clk = ~sys_clk;

    led_mode_ctrl_if bus ();

    led_mode_ctrl #(
        .TICK_CYCLES(TC),
        .BLINK_MS   (BM),
        .STEP_MS    (SM),
        .AUTO_MS    (AM)
    ) dut (
        .sys_clk(sys_clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int passes = 0;

    // Model state: mode, cycles since last mode change, ticks counted toward auto advance.
    logic [1:0] m_mode;
    int         m_k;
    int         m_at;
    logic [3:0] m_led;
    logic       m_ben;

    function automatic logic f_tick(int k);
        return ((k + 1) % TC) == 0;
    endfunction

    function automatic logic [1:0] f_next(logic [1:0] md, int k, int at, logic key, logic au);
        if (key) return md + 2'd1;
        if (au && md != 2'd0 && f_tick(k) && at == AM - 1) return (md == 2'd3) ? 2'd1 : md + 2'd1;
        return md;
    endfunction

    function automatic logic [3:0] f_led(logic [1:0] md, int k, logic [3:0] bl);
        case (md)
            2'd1:    return bl;
            2'd2:    return (((k / (BM * TC)) % 2) == 0) ? 4'b1111 : 4'b0000;
            2'd3:    return 4'b0001 << ((k / (SM * TC)) % 4);
            default: return 4'b0000;
        endcase
    endfunction

    always @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= 2'd0;
            m_k    <= 0;
            m_at   <= 0;
            m_led  <= 4'b0000;
            m_ben  <= 1'b0;
        end else begin
            m_mode <= f_next(m_mode, m_k, m_at, bus.key_next, bus.auto_en);
            m_k    <= (f_next(m_mode, m_k, m_at, bus.key_next, bus.auto_en) != m_mode) ? 0 : m_k + 1;
            m_at   <= (f_next(m_mode, m_k, m_at, bus.key_next, bus.auto_en) != m_mode
                       || !bus.auto_en || m_mode == 2'd0) ? 0 : m_at + (f_tick(m_k) ? 1 : 0);
            m_led  <= f_led(m_mode, m_k, bus.breath_led);
            m_ben  <= (m_mode == 2'd1);
        end
    end

    task automatic reset_dut();
        bus.key_next = 1'b0;
        bus.auto_en  = 1'b0;
        @(negedge sys_clk);
        rst_n = 1'b0;
        @(negedge sys_clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_key();
        bus.key_next = 1'b1;
        @(negedge sys_clk);
        bus.key_next = 1'b0;
    endtask

    task automatic test_reset();
        bus.key_next   = 1'b0;
        bus.auto_en    = 1'b0;
        bus.breath_led = 4'b0000;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.mode, bus.led, bus.breath_en} !== 7'b0) $display("[TB] FAIL reset_values got %b want 0000000", {bus.mode, bus.led, bus.breath_en});
        else passes++;
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge sys_clk);
            checks++;
            if ({bus.mode, bus.led, bus.breath_en} !== 7'b0) $display("[TB] FAIL idle_after_reset got %b want 0000000", {bus.mode, bus.led, bus.breath_en});
            else passes++;
        end
    endtask

    task automatic test_key_cycle();
        logic [1:0] exp_modes [4];
        exp_modes = '{2'd1, 2'd2, 2'd3, 2'd0};
        reset_dut();
        for (int p = 0; p < 4; p++) begin
            pulse_key();
            checks++;
            if (bus.mode !== exp_modes[p]) $display("[TB] FAIL key_step%0d mode got %0d want %0d", p, bus.mode, exp_modes[p]);
            else passes++;
            for (int c = 0; c < 19; c++) begin
                @(negedge sys_clk);
                checks++;
                if ({bus.mode, bus.led, bus.breath_en} !== {m_mode, m_led, m_ben})
                    $display("[TB] FAIL key_cycle_model got %b want %b", {bus.mode, bus.led, bus.breath_en}, {m_mode, m_led, m_ben});
                else passes++;
                checks++;
                if (bus.breath_en !== (exp_modes[p] == 2'd1)) $display("[TB] FAIL key_cycle_breath_en got %b want %b", bus.breath_en, exp_modes[p] == 2'd1);
                else passes++;
                if (exp_modes[p] == 2'd0) begin
                    checks++;
                    if (bus.led !== 4'b0000) $display("[TB] FAIL idle_led got %b want 0000", bus.led);
                    else passes++;
                end
            end
        end
    endtask

    task automatic test_breath();
        reset_dut();
        bus.breath_led = 4'b1010;
        pulse_key();
        repeat (5) @(negedge sys_clk);
        checks++;
        if (bus.led !== 4'b1010) $display("[TB] FAIL breath_pass_1010 got %b want 1010", bus.led);
        else passes++;
        bus.breath_led = 4'b0101;
        @(negedge sys_clk);
        checks++;
        if (bus.led !== 4'b0101) $display("[TB] FAIL breath_latency got %b want 0101", bus.led);
        else passes++;
        pulse_key();
        checks++;
        if (bus.mode !== 2'd2) $display("[TB] FAIL breath_to_blink mode got %0d want 2", bus.mode);
        else passes++;
        @(negedge sys_clk);
        checks++;
        if (bus.breath_en !== 1'b0) $display("[TB] FAIL breath_en_drop got %b want 0", bus.breath_en);
        else passes++;
    endtask

    task automatic test_blink();
        logic [3:0] exp;
        reset_dut();
        pulse_key();
        pulse_key();
        for (int i = 1; i <= 36; i++) begin
            @(negedge sys_clk);
            exp = (((i - 1) / 12) % 2 == 0) ? 4'b1111 : 4'b0000;
            checks++;
            if (bus.led !== exp) $display("[TB] FAIL blink_cycle%0d got %b want %b", i, bus.led, exp);
            else passes++;
            checks++;
            if (bus.led !== m_led) $display("[TB] FAIL blink_model got %b want %b", bus.led, m_led);
            else passes++;
        end
    endtask

    task automatic test_run();
        logic [3:0] exp;
        reset_dut();
        repeat (3) pulse_key();
        for (int i = 1; i <= 40; i++) begin
            @(negedge sys_clk);
            exp = 4'b0001 << (((i - 1) / 8) % 4);
            checks++;
            if (bus.led !== exp) $display("[TB] FAIL run_cycle%0d got %b want %b", i, bus.led, exp);
            else passes++;
        end
    endtask

    task automatic test_auto();
        reset_dut();
        pulse_key();
        pulse_key();
        bus.auto_en = 1'b1;
        pulse_key();
        for (int i = 1; i <= 24; i++) begin
            @(negedge sys_clk);
            checks++;
            if ({bus.mode, bus.led, bus.breath_en} !== {m_mode, m_led, m_ben})
                $display("[TB] FAIL auto_model got %b want %b", {bus.mode, bus.led, bus.breath_en}, {m_mode, m_led, m_ben});
            else passes++;
            if (i == 19) begin
                checks++;
                if (bus.mode !== 2'd3) $display("[TB] FAIL auto_early mode got %0d want 3", bus.mode);
                else passes++;
            end
            if (i == 20) begin
                checks++;
                if (bus.mode !== 2'd1) $display("[TB] FAIL auto_skip_idle mode got %0d want 1", bus.mode);
                else passes++;
            end
        end
        bus.auto_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        reset_dut();
        pulse_key();
        bus.auto_en = 1'b1;
        pulse_key();
        for (int i = 1; i <= 24; i++) begin
            @(negedge sys_clk);
            bus.key_next = 1'b0;
            checks++;
            if ({bus.mode, bus.led, bus.breath_en} !== {m_mode, m_led, m_ben})
                $display("[TB] FAIL collide_model got %b want %b", {bus.mode, bus.led, bus.breath_en}, {m_mode, m_led, m_ben});
            else passes++;
            if (i == 19) bus.key_next = 1'b1;
            if (i == 20 || i == 24) begin
                checks++;
                if (bus.mode !== 2'd3) $display("[TB] FAIL collide_single_step mode got %0d want 3", bus.mode);
                else passes++;
            end
        end
        bus.auto_en = 1'b0;
    endtask

    task automatic test_async_reset();
        int waited;
        reset_dut();
        repeat (3) pulse_key();
        waited = 0;
        while (bus.led !== 4'b0100 && waited < 40) begin
            @(negedge sys_clk);
            waited++;
        end
        checks++;
        if (bus.led !== 4'b0100) $display("[TB] FAIL run_reach_0100 got %b want 0100", bus.led);
        else passes++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.mode, bus.led, bus.breath_en} !== 7'b0) $display("[TB] FAIL async_reset got %b want 0000000", {bus.mode, bus.led, bus.breath_en});
        else passes++;
        @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);
        checks++;
        if (bus.mode !== 2'd0) $display("[TB] FAIL resume_idle mode got %0d want 0", bus.mode);
        else passes++;
        repeat (3) pulse_key();
        @(negedge sys_clk);
        checks++;
        if (bus.led !== 4'b0001) $display("[TB] FAIL run_reentry got %b want 0001", bus.led);
        else passes++;
    endtask

    task automatic test_random();
        reset_dut();
        bus.auto_en = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            @(negedge sys_clk);
            checks++;
            if ({bus.mode, bus.led, bus.breath_en} !== {m_mode, m_led, m_ben})
                $display("[TB] FAIL random_cycle%0d got %b want %b", c, {bus.mode, bus.led, bus.breath_en}, {m_mode, m_led, m_ben});
            else passes++;
            bus.key_next   = ($urandom_range(0, 15) == 0);
            bus.breath_led = 4'($urandom);
            if ($urandom_range(0, 63) == 0) bus.auto_en = ~bus.auto_en;
        end
        bus.key_next = 1'b0;
        bus.auto_en  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_key_cycle();
        test_breath();
        test_blink();
        test_run();
        test_auto();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
